// File: rtl/alu_issue_sequencer.sv
// Sequencer feeding the register-file ALU from a local program memory: fetch, pre-decode,
// issue over a valid/ack handshake, local jumps, halt/illegal/timeout termination.
module alu_issue_sequencer #(
   parameter int IMEM_DEPTH  = 64,
   parameter int PC_W        = 6,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_en,
   input  logic [PC_W-1:0] load_addr,
   input  logic [31:0]     load_data,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [PC_W-1:0] pc,
   output logic [31:0]     alu_instr,
   output logic            alu_valid,
   input  logic            alu_ack,
   output logic [15:0]     retired,
   output logic            err_illegal,
   output logic            err_timeout
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(IMEM_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   localparam logic [5:0]  OP_SPECIAL = 6'b000000;
   localparam logic [5:0]  OP_ADDI    = 6'b001000;
   localparam logic [5:0]  OP_ADDIU   = 6'b001001;
   localparam logic [5:0]  OP_SLTI    = 6'b001010;
   localparam logic [5:0]  OP_ANDI    = 6'b001100;
   localparam logic [5:0]  OP_ORI     = 6'b001101;
   localparam logic [5:0]  OP_JUMP    = 6'b010100;
   localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_RETIRE,
      S_FINISH
   } state_t;

   typedef enum logic [1:0] {
      K_ALU,
      K_JUMP,
      K_HALT,
      K_ILLEGAL
   } kind_t;

   logic [31:0]      mem [IMEM_DEPTH];
   logic [31:0]      fetch_word;
   logic [31:0]      ir;
   logic [CNT_W-1:0] wait_cnt;
   state_t           state;
   state_t           state_next;
   kind_t            kind;

   logic pc_clear;
   logic pc_jump;
   logic pc_step;
   logic ret_clear;
   logic ret_inc;
   logic err_clear;
   logic set_illegal;
   logic set_timeout;
   logic cnt_clear;
   logic cnt_inc;
   logic ir_load;

   // Halt is tested first: its all-ones opcode would otherwise fall into the illegal bucket.
   function automatic kind_t classify(input logic [31:0] w);
      kind_t k;
      k = K_ILLEGAL;
      if (w == HALT_WORD) begin
         k = K_HALT;
      end else begin
         case (w[31:26])
            OP_SPECIAL: begin
               case (w[5:0])
                  6'b100000, 6'b100001, 6'b100010, 6'b100011,
                  6'b100100, 6'b100101, 6'b000000, 6'b000010,
                  6'b101010: k = K_ALU;
                  default:   k = K_ILLEGAL;
               endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: k = K_ALU;
            OP_JUMP: k = K_JUMP;
            default: k = K_ILLEGAL;
         endcase
      end
      return k;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Program memory: host writes only while idle, synchronous read during FETCH.
   always_ff @(posedge clk) begin
      if (load_en && state == S_IDLE) begin
         mem[load_addr] <= load_data;
      end
      if (state == S_FETCH) begin
         fetch_word <= mem[pc];
      end
   end

   assign kind = classify(fetch_word);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      pc_clear    = 1'b0;
      pc_jump     = 1'b0;
      pc_step     = 1'b0;
      ret_clear   = 1'b0;
      ret_inc     = 1'b0;
      err_clear   = 1'b0;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      cnt_clear   = 1'b0;
      cnt_inc     = 1'b0;
      ir_load     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = S_FETCH;
               pc_clear   = 1'b1;
               ret_clear  = 1'b1;
               err_clear  = 1'b1;
            end
         end
         S_FETCH: begin
            state_next = S_DECODE;
         end
         S_DECODE: begin
            ir_load = 1'b1;
            case (kind)
               K_HALT: begin
                  state_next = S_FINISH;
               end
               K_ILLEGAL: begin
                  set_illegal = 1'b1;
                  state_next  = S_FINISH;
               end
               K_JUMP: begin
                  pc_jump    = 1'b1;
                  ret_inc    = 1'b1;
                  state_next = S_FETCH;
               end
               default: begin
                  cnt_clear  = 1'b1;
                  state_next = S_ISSUE;
               end
            endcase
         end
         S_ISSUE: begin
            // An ack on the last allowed cycle still wins over the timeout.
            if (alu_ack) begin
               state_next = S_RETIRE;
            end else if (wait_cnt == CNT_LAST) begin
               set_timeout = 1'b1;
               state_next  = S_FINISH;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_RETIRE: begin
            ret_inc = 1'b1;
            if (pc == PC_LAST) begin
               state_next = S_FINISH;
            end else begin
               pc_step    = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_FINISH: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= '0;
         retired     <= '0;
         err_illegal <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (pc_clear) begin
            pc <= '0;
         end else if (pc_jump) begin
            pc <= fetch_word[PC_W-1:0];
         end else if (pc_step) begin
            pc <= pc + PC_W'(1);
         end
         if (ret_clear) begin
            retired <= '0;
         end else if (ret_inc) begin
            retired <= sat_inc(retired);
         end
         if (err_clear) begin
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
         end else begin
            if (set_illegal) err_illegal <= 1'b1;
            if (set_timeout) err_timeout <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ir_load) begin
         ir <= fetch_word;
      end
      if (cnt_clear) begin
         wait_cnt <= '0;
      end else if (cnt_inc) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FINISH);
   assign alu_valid = (state == S_ISSUE);
   assign alu_instr = alu_valid ? ir : 32'd0;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer: a program-walking trace model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_alu_issue_sequencer;

   localparam int NEVER = 1000;
   localparam logic [31:0] W_ADDU = 32'h0211_1821;
   localparam logic [31:0] W_ORI  = 32'h3404_000F;
   localparam logic [31:0] W_ADDI = 32'h2001_0001;
   localparam logic [31:0] W_JMP5 = 32'h5000_0005;
   localparam logic [31:0] W_LW   = 32'h8C00_0000;
   localparam logic [31:0] W_HALT = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_en = 1'b0;
   logic [5:0]  load_addr = '0;
   logic [31:0] load_data = '0;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic [5:0]  pc;
   logic [31:0] alu_instr;
   logic        alu_valid;
   logic        alu_ack = 1'b0;
   logic [15:0] retired;
   logic        err_illegal;
   logic        err_timeout;

   alu_issue_sequencer #(.IMEM_DEPTH(64), .PC_W(6), .ACK_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .start(start), .busy(busy), .done(done), .pc(pc), .alu_instr(alu_instr),
      .alu_valid(alu_valid), .alu_ack(alu_ack), .retired(retired),
      .err_illegal(err_illegal), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic [5:0]  pc;
      logic        valid;
      logic [31:0] instr;
      logic [15:0] ret;
      logic        ei;
      logic        et;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_m [64];
   logic [31:0] issued[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          ack_delay = 0;
   int          vcnt = 0;
   int          vcycles = 0;
   bit          got_done;
   int          lat;
   logic [5:0]  done_pc;
   logic [15:0] done_ret;
   logic        done_ei;
   logic        done_et;
   bit          pend_load = 0;
   logic [5:0]  pend_addr;
   logic [31:0] pend_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_alu_word(input logic [31:0] w);
      if (w[31:26] == 6'd0)
         return w[5:0] inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2A};
      return w[31:26] inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A};
   endfunction

   function automatic void push(logic b, logic d, int p, logic v, logic [31:0] i, int r,
                                logic ei, logic et);
      exp_t e;
      e.busy = b; e.done = d; e.pc = 6'(p); e.valid = v; e.instr = i;
      e.ret = 16'(r); e.ei = ei; e.et = et;
      exp_q.push_back(e);
   endfunction

   // Walks the program from pc 0 and lists what every cycle after start must show.
   task automatic build_expect();
      int p = 0;
      int r = 0;
      bit fin = 0;
      logic ei = 0;
      logic et = 0;
      logic [31:0] w;
      exp_q.delete();
      while (!fin && exp_q.size() < 4000) begin
         push(1, 0, p, 0, 0, r, 0, 0);
         push(1, 0, p, 0, 0, r, 0, 0);
         w = mem_m[p];
         if (w == W_HALT) begin
            fin = 1;
         end else if (w[31:26] == 6'b010100) begin
            r = (r >= 65535) ? 65535 : r + 1;
            p = int'(w[5:0]);
         end else if (!is_alu_word(w)) begin
            ei = 1; fin = 1;
         end else if (ack_delay < 16) begin
            repeat (ack_delay + 1) push(1, 0, p, 1, w, r, 0, 0);
            push(1, 0, p, 0, 0, r, 0, 0);
            r = (r >= 65535) ? 65535 : r + 1;
            if (p == 63) fin = 1;
            else p = p + 1;
         end else begin
            repeat (16) push(1, 0, p, 1, w, r, 0, 0);
            et = 1; fin = 1;
         end
      end
      push(1, 1, p, 0, 0, r, ei, et);
      push(0, 0, p, 0, 0, r, ei, et);
   endtask

   // ALU stand-in: delay 0 means ack tied high, otherwise ack on the delay-th extra valid cycle.
   always @(posedge clk) begin
      #1;
      if (ack_delay == 0) begin
         alu_ack = 1'b1;
      end else if (alu_valid) begin
         alu_ack = (vcnt == ack_delay);
         vcnt++;
      end else begin
         alu_ack = 1'b0;
         vcnt = 0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("cycle", 64'({busy, done, pc, alu_valid, alu_instr, retired, err_illegal, err_timeout}),
             64'(e));
      end
      if (alu_valid) begin
         vcycles++;
         if (alu_ack) issued.push_back(alu_instr);
      end
   end

   task automatic load_word(input int a, input logic [31:0] d);
      @(negedge clk);
      load_en = 1'b1; load_addr = 6'(a); load_data = d; mem_m[a] = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic run(input int delay, input bit poke);
      ack_delay = delay;
      issued.delete();
      vcycles = 0; got_done = 0; lat = 0;
      @(negedge clk);
      start = 1'b1;
      if (pend_load) begin
         load_en = 1'b1; load_addr = pend_addr; load_data = pend_data;
         mem_m[pend_addr] = pend_data; pend_load = 0;
      end
      @(posedge clk);
      #1 build_expect();
      for (int k = 1; k <= 2000 && !got_done; k++) begin
         @(negedge clk);
         start = 1'b0; load_en = 1'b0;
         if (poke && k == 5) begin
            start = 1'b1; load_en = 1'b1; load_addr = 6'd0; load_data = W_LW;
         end
         if (done) begin
            got_done = 1; lat = k; done_pc = pc; done_ret = retired;
            done_ei = err_illegal; done_et = err_timeout;
         end
      end
      @(negedge clk);
      start = 1'b0; load_en = 1'b0;
      n_tests++;
      if (!got_done) begin
         n_fail++;
         $display("FAIL run_done: no done within 2000 cycles");
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", 64'({busy, done, pc, alu_valid, alu_instr, retired, err_illegal, err_timeout}),
          64'd0);
      rst = 1'b0;

      // Two ALU words then halt; the halt is written in the same cycle as start.
      load_word(0, W_ADDU);
      load_word(1, W_ORI);
      pend_load = 1; pend_addr = 6'd2; pend_data = W_HALT;
      run(0, 0);
      chk("s1_n_issued", 64'(issued.size()), 64'd2);
      if (issued.size() == 2) begin
         chk("s1_issue0", 64'(issued[0]), 64'h0211_1821);
         chk("s1_issue1", 64'(issued[1]), 64'h3404_000F);
      end
      chk("s1_done_latency", 64'(lat), 64'd11);
      chk("s1_retired", 64'(done_ret), 64'd2);
      chk("s1_errors", 64'({done_ei, done_et}), 64'd0);

      // Jump to 5, halt there.
      load_word(0, W_JMP5);
      load_word(5, W_HALT);
      run(0, 0);
      chk("s2_valid_cycles", 64'(vcycles), 64'd0);
      chk("s2_pc", 64'(done_pc), 64'd5);
      chk("s2_retired", 64'(done_ret), 64'd1);

      // Illegal opcode.
      load_word(0, W_LW);
      run(0, 0);
      chk("s3_err_illegal", 64'(done_ei), 64'd1);
      chk("s3_retired", 64'(done_ret), 64'd0);

      // Ack never arrives; start and load attempted mid-run must be ignored.
      load_word(0, W_ADDI);
      load_word(1, W_HALT);
      run(NEVER, 1);
      chk("s4_valid_cycles", 64'(vcycles), 64'd16);
      chk("s4_err_timeout", 64'(done_et), 64'd1);
      chk("s4_err_illegal_cleared", 64'(done_ei), 64'd0);
      chk("s4_retired", 64'(done_ret), 64'd0);

      // Same program, ack after two wait cycles; word 0 must still be the addi.
      run(2, 0);
      chk("s5_n_issued", 64'(issued.size()), 64'd1);
      if (issued.size() == 1) chk("s5_issue0", 64'(issued[0]), 64'h2001_0001);
      chk("s5_valid_cycles", 64'(vcycles), 64'd3);
      chk("s5_retired", 64'(done_ret), 64'd1);
      chk("s5_err_timeout", 64'(done_et), 64'd0);

      // Full memory of ALU words, no halt.
      for (int a = 0; a < 64; a++) load_word(a, W_ADDU);
      run(1, 0);
      chk("s6_retired", 64'(done_ret), 64'd64);
      chk("s6_pc", 64'(done_pc), 64'd63);
      chk("s6_pc_after", 64'(pc), 64'd63);

      // Reset during the second ISSUE cycle.
      ack_delay = NEVER;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 build_expect();
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("s7_first_issue", 64'(alu_valid), 64'd1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("s7_rst_state", 64'({busy, done, alu_valid, pc, retired}), 64'd0);
      load_word(1, W_HALT);
      run(0, 0);
      chk("s7_rerun_retired", 64'(done_ret), 64'd1);
      if (issued.size() == 1) chk("s7_rerun_issue", 64'(issued[0]), 64'h0211_1821);
      else chk("s7_rerun_n_issued", 64'(issued.size()), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
